// File: rtl/fe_mul_arbiter.sv
// Shares one fe_mulx field multiplier among NCH clients, using round-robin or fixed-priority arbitration.
// Operands and result are registered. A watchdog aborts a multiplication that never completes.
module fe_mul_arbiter #(
  parameter int NCH      = 4,
  parameter int WIDTH    = 320,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       req_valid,
  input  logic [NCH*WIDTH-1:0] req_op_a,
  input  logic [NCH*WIDTH-1:0] req_op_b,
  output logic [NCH-1:0]       req_done,
  output logic [WIDTH-1:0]     req_res,
  output logic                 req_err,
  output logic [WIDTH-1:0]     mul_op_a,
  output logic [WIDTH-1:0]     mul_op_b,
  output logic                 mul_valid,
  input  logic [WIDTH-1:0]     mul_res,
  input  logic                 mul_done,
  output logic [2:0]           grant,
  output logic                 busy,
  output logic                 err_sticky
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state;
  logic [2:0]      ptr;
  logic [CW-1:0]   wd_cnt;
  logic [2:0]      pick;
  logic            pick_ok;
  logic [NCH-1:0]  shifted;

  // Winner selection. Loops run from the lowest to the highest priority, so the
  // last hit, which has the highest priority, is the one that remains.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    pick    = '0;
    pick_ok = 1'b0;
    shifted = '0;
    if (ARB_MODE == 0) begin
      for (int off = NCH; off >= 1; off--) begin
        shifted = req_valid >> ((int'(ptr) + off) % NCH);
        if (shifted[0]) begin
          pick    = 3'((int'(ptr) + off) % NCH);
          pick_ok = 1'b1;
        end
      end
    end else begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (req_valid[i]) begin
          pick    = 3'(i);
          pick_ok = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (!rst) begin
      state      <= S_IDLE;
      ptr        <= 3'(NCH - 1);
      wd_cnt     <= '0;
      grant      <= '0;
      mul_op_a   <= '0;
      mul_op_b   <= '0;
      mul_valid  <= 1'b0;
      req_done   <= '0;
      req_res    <= '0;
      req_err    <= 1'b0;
      busy       <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      mul_valid <= 1'b0;
      req_done  <= '0;
      req_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_ok) begin
            grant     <= pick;
            mul_op_a  <= req_op_a[int'(pick)*WIDTH +: WIDTH];
            mul_op_b  <= req_op_b[int'(pick)*WIDTH +: WIDTH];
            mul_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wd_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          // A real completion takes priority over a timeout that expires in the same cycle.
          if (mul_done) begin
            req_res  <= mul_res;
            req_err  <= 1'b0;
            req_done <= NCH'(1) << grant;
            state    <= S_RESP;
          end else if (TIMEOUT != 0 && wd_cnt == TO_LAST) begin
            req_res    <= '0;
            req_err    <= 1'b1;
            err_sticky <= 1'b1;
            req_done   <= NCH'(1) << grant;
            state      <= S_RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (ARB_MODE == 0) ptr <= grant;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fe_mul_arbiter.sv
// Self-checking bench for fe_mul_arbiter. Instance 0 runs round-robin and instance 1 runs fixed priority.
// A transaction-level model is compared against both instances every cycle, and directed literals pin key values.
module tb_fe_mul_arbiter;

  localparam int NCH = 4;
  localparam int W   = 320;
  localparam int TO  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]   req_valid [2];
  logic [NCH*W-1:0] req_op_a  [2];
  logic [NCH*W-1:0] req_op_b  [2];
  logic [NCH-1:0]   req_done  [2];
  logic [W-1:0]     req_res   [2];
  logic             req_err   [2];
  logic [W-1:0]     mul_op_a  [2];
  logic [W-1:0]     mul_op_b  [2];
  logic             mul_valid [2];
  logic [W-1:0]     mul_res   [2];
  logic             mul_done  [2];
  logic [2:0]       grant     [2];
  logic             busy      [2];
  logic             err_sticky[2];

  fe_mul_arbiter #(.NCH(NCH), .WIDTH(W), .ARB_MODE(0), .TIMEOUT(TO)) dut_rr (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_op_a(req_op_a[0]), .req_op_b(req_op_b[0]),
    .req_done(req_done[0]), .req_res(req_res[0]), .req_err(req_err[0]),
    .mul_op_a(mul_op_a[0]), .mul_op_b(mul_op_b[0]), .mul_valid(mul_valid[0]),
    .mul_res(mul_res[0]), .mul_done(mul_done[0]), .grant(grant[0]), .busy(busy[0]),
    .err_sticky(err_sticky[0]));

  fe_mul_arbiter #(.NCH(NCH), .WIDTH(W), .ARB_MODE(1), .TIMEOUT(TO)) dut_fx (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_op_a(req_op_a[1]), .req_op_b(req_op_b[1]),
    .req_done(req_done[1]), .req_res(req_res[1]), .req_err(req_err[1]),
    .mul_op_a(mul_op_a[1]), .mul_op_b(mul_op_b[1]), .mul_valid(mul_valid[1]),
    .mul_res(mul_res[1]), .mul_done(mul_done[1]), .grant(grant[1]), .busy(busy[1]),
    .err_sticky(err_sticky[1]));

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // age counts the cycles a transaction has existed. Age 1 is the issue cycle.
  // The watchdog therefore expires in the cycle of age TO+1.
  bit           m_txn   [2];
  bit           m_fin   [2];
  int           m_age   [2];
  int           m_owner [2];
  int           m_rr    [2];
  logic [W-1:0] m_a     [2];
  logic [W-1:0] m_b     [2];
  logic [W-1:0] m_res   [2];
  bit           m_err   [2];
  bit           m_sticky[2];

  task automatic model_step(input int d);
    int w;
    w = -1;
    if (!rst) begin
      m_txn[d] = 0; m_fin[d] = 0; m_age[d] = 0; m_owner[d] = 0; m_rr[d] = NCH - 1;
      m_a[d] = '0; m_b[d] = '0; m_res[d] = '0; m_err[d] = 0; m_sticky[d] = 0;
    end else if (m_fin[d]) begin
      m_fin[d] = 0;
      m_txn[d] = 0;
      if (d == 0) m_rr[d] = m_owner[d];
    end else if (m_txn[d]) begin
      if (m_age[d] >= 2 && mul_done[d]) begin
        m_fin[d] = 1; m_res[d] = mul_res[d]; m_err[d] = 0;
      end else if (m_age[d] == TO + 1) begin
        m_fin[d] = 1; m_res[d] = '0; m_err[d] = 1; m_sticky[d] = 1;
      end else begin
        m_age[d]++;
      end
    end else if (req_valid[d] != '0) begin
      if (d == 0) begin
        for (int off = 1; off <= NCH; off++)
          if (w < 0 && req_valid[d][(m_rr[d] + off) % NCH]) w = (m_rr[d] + off) % NCH;
      end else begin
        for (int i = NCH - 1; i >= 0; i--)
          if (req_valid[d][i]) w = i;
      end
      m_owner[d] = w;
      m_a[d]     = req_op_a[d][w*W +: W];
      m_b[d]     = req_op_b[d][w*W +: W];
      m_txn[d]   = 1;
      m_age[d]   = 1;
    end
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) model_step(d);
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    logic [NCH-1:0] e_done;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        e_done = '0;
        if (m_fin[d]) e_done[m_owner[d]] = 1'b1;
        check($sformatf("d%0d req_done", d),   req_done[d],   e_done);
        check($sformatf("d%0d req_res", d),    req_res[d],    m_res[d]);
        check($sformatf("d%0d req_err", d),    req_err[d],    m_fin[d] && m_err[d]);
        check($sformatf("d%0d mul_op_a", d),   mul_op_a[d],   m_a[d]);
        check($sformatf("d%0d mul_op_b", d),   mul_op_b[d],   m_b[d]);
        check($sformatf("d%0d mul_valid", d),  mul_valid[d],  m_txn[d] && !m_fin[d] && m_age[d] == 1);
        check($sformatf("d%0d grant", d),      grant[d],      m_owner[d]);
        check($sformatf("d%0d busy", d),       busy[d],       m_txn[d]);
        check($sformatf("d%0d err_sticky", d), err_sticky[d], m_sticky[d]);
      end
    end
  end

  // ---------------- clients and multiplier stub ----------------
  int             lat   [2];
  int             cnt   [2];
  bit             done_in_issue[2];
  logic [NCH-1:0] hold  [2];
  logic [W-1:0]   pa    [2];
  logic [W-1:0]   pb    [2];

  // A lat of 0 makes the stub never answer.
  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NCH; i++)
        if (req_done[d][i] && !hold[d][i]) req_valid[d][i] = 1'b0;
      mul_done[d] = 1'b0;
      if (cnt[d] > 0) begin
        cnt[d]--;
        if (cnt[d] == 0) begin
          mul_done[d] = 1'b1;
          mul_res[d]  = pa[d] * pb[d];
        end
      end
      if (mul_valid[d]) begin
        pa[d]  = mul_op_a[d];
        pb[d]  = mul_op_b[d];
        cnt[d] = lat[d];
        if (done_in_issue[d]) begin
          mul_done[d] = 1'b1;
          mul_res[d]  = '1;
        end
      end
    end
  endtask

  task automatic wait_done(input int d, input int limit, output int ticks);
    ticks = 0;
    do begin
      tick();
      ticks++;
    end while (req_done[d] == '0 && ticks < limit);
    if (req_done[d] == '0) begin
      n_checks++;
      n_errors++;
      $display("FAIL d%0d wait_done: no req_done within %0d cycles", d, limit);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int t;
    int fair_exp [4];
    fair_exp = '{55, 72, 91, 112};
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = '0; req_op_a[d] = '0; req_op_b[d] = '0;
      mul_done[d] = 1'b0; mul_res[d] = '0; lat[d] = 1; cnt[d] = 0;
      done_in_issue[d] = 1'b0; hold[d] = '0; pa[d] = '0; pb[d] = '0;
    end
    repeat (2) tick();
    rst = 1'b1;
    chk_en = 1'b1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d reset busy", d),  busy[d],       0);
      check($sformatf("d%0d reset grant", d), grant[d],      0);
      check($sformatf("d%0d reset res", d),   req_res[d],    0);
      check($sformatf("d%0d reset sticky", d), err_sticky[d], 0);
    end

    // Single request on ch2. The client drops req_valid once granted and must still get req_done.
    req_op_a[0][2*W +: W] = 320'h2;
    req_op_b[0][2*W +: W] = 320'h3;
    req_valid[0][2] = 1'b1;
    tick();
    check("single mul_valid@k+1", mul_valid[0], 1);
    check("single grant", grant[0], 2);
    check("single mul_op_a", mul_op_a[0], 320'h2);
    req_valid[0][2] = 1'b0;
    tick();
    check("single no early done", req_done[0], 0);
    tick();
    check("single req_done@k+3", req_done[0], 4'b0100);
    check("single req_res", req_res[0], 320'h6);
    check("single req_err", req_err[0], 0);
    tick();
    check("single res retained", req_res[0], 320'h6);
    check("single idle", busy[0], 0);

    // Fixed priority with ch0 and ch3 requesting. A mul_done pulse in ISSUE carries junk and must be ignored.
    req_op_a[1][0*W +: W] = 320'd7;  req_op_b[1][0*W +: W] = 320'd9;
    req_op_a[1][3*W +: W] = 320'd13; req_op_b[1][3*W +: W] = 320'd17;
    hold[1] = 4'b1001; req_valid[1] = 4'b1001; lat[1] = 2; done_in_issue[1] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      wait_done(1, 40, t);
      check($sformatf("fixed grant #%0d", n), grant[1], 0);
      check($sformatf("fixed res #%0d", n), req_res[1], 320'd63);
    end
    hold[1][0] = 1'b0; req_valid[1][0] = 1'b0;
    wait_done(1, 40, t);
    check("fixed grant after release", grant[1], 3);
    check("fixed res ch3", req_res[1], 320'd221);
    hold[1] = '0; req_valid[1] = '0; done_in_issue[1] = 1'b0;
    repeat (2) tick();

    // Watchdog: the stub never answers, so the transaction ends 17 cycles after ISSUE.
    lat[0] = 0;
    req_op_a[0][3*W +: W] = 320'd5; req_op_b[0][3*W +: W] = 320'd5;
    req_valid[0][3] = 1'b1;
    tick();
    check("timeout issue", mul_valid[0], 1);
    wait_done(0, 40, t);
    check("timeout cycles after ISSUE", t, 17);
    check("timeout req_done", req_done[0], 4'b1000);
    check("timeout req_err", req_err[0], 1);
    check("timeout req_res", req_res[0], 0);
    check("timeout sticky", err_sticky[0], 1);
    repeat (5) tick();
    check("sticky holds", err_sticky[0], 1);
    check("timeout idle", busy[0], 0);

    // Reset in the middle of WAIT, followed by a late mul_done from the aborted operation.
    req_op_a[0][1*W +: W] = 320'd3; req_op_b[0][1*W +: W] = 320'd4;
    req_valid[0][1] = 1'b1;
    repeat (4) tick();
    check("pre-reset busy", busy[0], 1);
    req_valid[0] = '0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid reset busy", busy[0], 0);
    check("mid reset grant", grant[0], 0);
    check("mid reset mul_op_a", mul_op_a[0], 0);
    check("mid reset sticky", err_sticky[0], 0);
    mul_done[0] = 1'b1;
    mul_res[0]  = 320'hdead;
    tick();
    for (int n = 0; n < 3; n++) begin
      tick();
      check("late done ignored", req_done[0], 0);
      check("late done res", req_res[0], 0);
    end

    // Round-robin fairness starting from channel 0 after reset.
    lat[0] = 2;
    for (int i = 0; i < NCH; i++) begin
      req_op_a[0][i*W +: W] = W'(i + 5);
      req_op_b[0][i*W +: W] = W'(i + 11);
    end
    hold[0] = 4'b1111; req_valid[0] = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      wait_done(0, 40, t);
      check($sformatf("rr grant #%0d", n), grant[0], n % 4);
      check($sformatf("rr res #%0d", n), req_res[0], fair_exp[n % 4]);
      check($sformatf("rr err #%0d", n), req_err[0], 0);
    end
    hold[0] = '0; req_valid[0] = '0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fe_mul_arbiter.md
Name: fe_mul_arbiter

Overview:
- Round-robin or fixed-priority arbiter that lets NCH field-arithmetic clients share one fe_mulx multiplier.
- Replaces the one-client-per-multiplier wiring used by ge_double_scalarmult_vartime, so that multiple group-element engines (double-scalarmult, verify, keygen) can time-share a single multiplier.
- Registers the operands and result, and adds a watchdog with error reporting.

Parameters:
- NCH, 4, number of client channels (2..8).
- WIDTH, 320, field-element width in bits (10 limbs x 32).
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- TIMEOUT, 1024, maximum cycles spent in WAIT before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low.
- req_valid  in  NCH  per-channel request level; held high until that channel's req_done.
- req_op_a  in  NCH*WIDTH  channel i operand A at bits [i*WIDTH +: WIDTH].
- req_op_b  in  NCH*WIDTH  channel i operand B, same packing.
- req_done  out  NCH  one-cycle pulse to the granted channel; req_res is valid in that cycle.
- req_res  out  WIDTH  registered product, broadcast to all channels.
- req_err  out  1  high together with req_done when the transaction timed out.
- mul_op_a  out  WIDTH  operand A to fe_mulx; held stable from ISSUE until the transaction ends.
- mul_op_b  out  WIDTH  operand B to fe_mulx; same hold rule.
- mul_valid  out  1  one-cycle start pulse to fe_mulx.
- mul_res  in  WIDTH  fe_mulx result.
- mul_done  in  1  fe_mulx completion pulse; mul_res is valid in that cycle.
- grant  out  3  index of the current or last granted channel.
- busy  out  1  high whenever state != IDLE.
- err_sticky  out  1  set on any timeout; cleared only by reset.

Behaviour:
- Reset (rst==0 at an edge):
  - State goes to IDLE.
  - All outputs are 0: req_done, req_res, req_err, mul_op_a/b, mul_valid, grant, busy, err_sticky.
  - Round-robin pointer is set to NCH-1, so channel 0 has first priority.
  - Reset mid-transaction aborts it with no req_done. A mul_done from the aborted operation that arrives later is ignored (the state is IDLE).
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid bit is set, select a winner:
    - RR mode: search from ptr+1 mod NCH upward.
    - Fixed mode: lowest set index.
  - On selection, latch the winner's operands into mul_op_a/b, set grant, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: mul_valid=1 for exactly this cycle; clear the watchdog counter; go to WAIT.
- WAIT:
  - If mul_done: latch mul_res into req_res, set req_err=0, go to RESP.
  - Else if TIMEOUT!=0 and the counter reaches TIMEOUT-1: set req_res=0, req_err=1, err_sticky=1, go to RESP.
  - Else increment the counter.
- RESP:
  - req_done[grant]=1 for one cycle.
  - In RR mode, ptr<=grant.
  - Go to IDLE.
  - Requests are not evaluated in RESP. The client drops req_valid at the edge where it samples req_done, so the next IDLE cycle does not see a stale request.
- Latency:
  - req_valid sampled in IDLE at cycle k: mul_valid at k+1, req_done at m+1, where m is the cycle of mul_done.
  - Minimum is k+3 when mul_done arrives in the cycle after ISSUE.
- mul_done outside WAIT (including in ISSUE) is ignored; no response is generated from it.
- At most one multiplication is outstanding. Throughput is one transaction per (multiplier latency + 3) cycles.
- Changes to req_op of the granted channel after latching have no effect. Changes to req_valid of non-granted channels only affect the next arbitration.
- A client dropping req_valid after being granted does not cancel the transaction; req_done is still pulsed.
- Fairness (RR): with all NCH channels requesting continuously, grants cycle 0,1,..,NCH-1,0. No channel waits more than NCH-1 transactions.
- mul_op_a/b retain the last operands when idle; req_res retains the last result until the next RESP.

Test Plan:
- Single request: ch2 requests with op_a=320'h2, op_b=320'h3 → mul_valid 1 cycle after sampling; req_done[2] with req_res=320'h6 one cycle after mul_done; grant=2; req_err=0.
- RR fairness: NCH=4, all 4 channels hold req_valid continuously for 8 transactions → grant sequence 0,1,2,3,0,1,2,3; every req_res matches fe_mul of that channel's operands.
- Fixed priority: ARB_MODE=1, ch0 and ch3 continuously requesting → ch0 granted every time and ch3 starved. Releasing ch0 gives the next grant to ch3.
- Timeout: TIMEOUT=16, stub multiplier never raises mul_done → req_done and req_err high exactly 17 cycles after ISSUE; req_res=0; err_sticky stays 1 until rst=0.
- Reset mid-WAIT: assert rst=0 for one cycle, then have a late mul_done arrive → no req_done; busy=0; all outputs 0. The next request completes normally from channel 0 priority.
- Integration: ge_double_scalarmult_vartime on ch1 with the standard vectors (A_Z=1, given a/b), plus a dummy client hammering ch0 → R.X = ff8c1eb0…010bc5a4, R.Y = ff7805a5…01658970, R.Z = 00053a81…ffd1a58d, all unchanged from single-client operation.
